// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, reset PC,
// bubble instruction and the J-type target helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // j/jal target: upper nibble of the delay-slot PC plus the 26-bit index
    function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                                input logic [31:0] instr);
        return {pc4[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for a fetched instruction and its PC+4. Catches a
// bus response that arrives while ID is stalled. Clear beats write beats read.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_i,
    input  logic [31:0] wr_instr_i,
    input  logic [31:0] wr_pc4_i,
    input  logic        rd_i,
    input  logic        clr_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q,   pc4_d;

    // next entry contents
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (clr_i) begin
            valid_d = 1'b0;
        end else if (wr_i) begin
            valid_d = 1'b1;
            instr_d = wr_instr_i;
            pc4_d   = wr_pc4_i;
        end else if (rd_i) begin
            valid_d = 1'b0;
        end
    end

    // entry registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP;
            pc4_q   <= 32'h0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: fetch PC, single-outstanding SRAM-like instruction bus,
// IF/ID register, delay-slot aware redirects and CP0 flushes.
// Optional macro FETCH_ADEL_CHECK_EN: misaligned fetch raises AdEL into ID
// instead of issuing a bus request.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no request outstanding; request when the skid is empty
// WAIT  | request accepted, waiting for its read data
// DROP  | request accepted before a flush; its data is discarded
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    input  logic        id_stall_i,
    input  logic        do_branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        jump_flag_i,
    input  logic        jr_flag_i,
    input  logic [31:0] jr_addr_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc4_o,
    output logic        id_valid_o
`ifdef FETCH_ADEL_CHECK_EN
    ,
    output logic        id_adel_o,
    output logic [31:0] id_badvaddr_o
`endif
);

    import cpu_pkg::*;

    fetch_state_t state_q, state_d;

    logic [31:0] pc_q,        pc_d;
    logic [31:0] target_q,    target_d;
    logic [31:0] ds_addr_q,   ds_addr_d;
    logic [31:0] req_pc4_q,   req_pc4_d;
    logic        redirect_pending_q, redirect_pending_d;
    logic        req_en_q,    req_en_d;

    logic [31:0] id_instr_q,  id_instr_d;
    logic [31:0] id_pc4_q,    id_pc4_d;
    logic        id_valid_q,  id_valid_d;

    logic        skid_valid, skid_wr, skid_rd;
    logic [31:0] skid_instr, skid_pc4;

    logic        use_target;
    logic [31:0] req_addr, req_aligned;
    logic        req_ok, addr_hs, rsp_valid, ifid_open;
    logic        redirect_fire;
    logic [31:0] redirect_tgt;

`ifdef FETCH_ADEL_CHECK_EN
    logic        halt_q,      halt_d;
    logic        id_adel_q,   id_adel_d;
    logic [31:0] id_badvaddr_q, id_badvaddr_d;
    logic        adel_hit;
`endif

    // issue address selection and request qualification
    always_comb begin
        // the delay slot goes out first; once pc_q has moved past it, the target
        use_target  = redirect_pending_q && (pc_q != ds_addr_q);
        req_addr    = use_target ? target_q : pc_q;
        req_aligned = req_addr & ~32'h0000_0003;
`ifdef FETCH_ADEL_CHECK_EN
        adel_hit = req_en_q && (state_q == IDLE) && !skid_valid && !halt_q
                   && (req_addr[1:0] != 2'b00);
        req_ok   = req_en_q && (state_q == IDLE) && !skid_valid && !halt_q
                   && (req_addr[1:0] == 2'b00);
`else
        req_ok   = req_en_q && (state_q == IDLE) && !skid_valid;
`endif
        addr_hs       = req_ok && inst_addr_ok_i;
        rsp_valid     = inst_data_ok_i && (state_q == WAIT);
        ifid_open     = !id_valid_q || !id_stall_i;
        redirect_fire = id_valid_q && !id_stall_i
                        && (do_branch_i || jump_flag_i || jr_flag_i);
        if (jr_flag_i) begin
            redirect_tgt = jr_addr_i;
        end else if (jump_flag_i) begin
            redirect_tgt = jump_target(id_pc4_q, id_instr_q);
        end else begin
            redirect_tgt = branch_addr_i;
        end
    end

    assign inst_req_o = req_ok;
`ifdef FETCH_ADEL_CHECK_EN
    assign inst_addr_o = req_addr;
`else
    assign inst_addr_o = req_aligned;
`endif

    // bus FSM next state; a flush that coincides with the data beat finishes
    // the transaction outright since nothing is left to drop
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (addr_hs) state_d = flush_i ? DROP : WAIT;
            WAIT: begin
                if (inst_data_ok_i)  state_d = IDLE;
                else if (flush_i)    state_d = DROP;
            end
            DROP: if (inst_data_ok_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // response routing into the skid: only when IF/ID cannot take it directly
    always_comb begin
        skid_wr = rsp_valid && !flush_i && !(ifid_open && !skid_valid);
        skid_rd = ifid_open && skid_valid && !flush_i;
    end

    // IF/ID register: skid first, then bus data, otherwise a bubble
    always_comb begin
        id_instr_d = id_instr_q;
        id_pc4_d   = id_pc4_q;
        id_valid_d = id_valid_q;
`ifdef FETCH_ADEL_CHECK_EN
        id_adel_d     = id_adel_q;
        id_badvaddr_d = id_badvaddr_q;
        halt_d        = halt_q;
`endif
        if (flush_i) begin
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
`ifdef FETCH_ADEL_CHECK_EN
            id_adel_d  = 1'b0;
            halt_d     = 1'b0;
`endif
        end else if (ifid_open) begin
`ifdef FETCH_ADEL_CHECK_EN
            id_adel_d = 1'b0;
`endif
            if (skid_valid) begin
                id_valid_d = 1'b1;
                id_instr_d = skid_instr;
                id_pc4_d   = skid_pc4;
            end else if (rsp_valid) begin
                id_valid_d = 1'b1;
                id_instr_d = inst_rdata_i;
                id_pc4_d   = req_pc4_q;
            end else begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
`ifdef FETCH_ADEL_CHECK_EN
                // misaligned fetch: hand ID a faulting bubble and stop fetching
                if (adel_hit) begin
                    id_adel_d     = 1'b1;
                    id_badvaddr_d = req_addr;
                    halt_d        = 1'b1;
                end
`endif
            end
        end
    end

    // fetch PC and redirect bookkeeping
    always_comb begin
        pc_d               = pc_q;
        target_d           = target_q;
        ds_addr_d          = ds_addr_q;
        req_pc4_d          = req_pc4_q;
        redirect_pending_d = redirect_pending_q;
        req_en_d           = 1'b1;
        if (flush_i) begin
            pc_d               = flush_pc_i;
            redirect_pending_d = 1'b0;
        end else begin
            if (addr_hs) begin
                pc_d      = req_aligned + 32'd4;
                req_pc4_d = req_aligned + 32'd4;
                if (use_target) redirect_pending_d = 1'b0;
            end
            if (redirect_fire) begin
                target_d           = redirect_tgt;
                ds_addr_d          = id_pc4_q;
                redirect_pending_d = 1'b1;
            end
        end
    end

    // state registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q            <= IDLE;
            pc_q               <= RESET_PC;
            target_q           <= 32'h0;
            ds_addr_q          <= 32'h0;
            req_pc4_q          <= 32'h0;
            redirect_pending_q <= 1'b0;
            req_en_q           <= 1'b0;
            id_instr_q         <= NOP_INSTR;
            id_pc4_q           <= 32'h0;
            id_valid_q         <= 1'b0;
        end else begin
            state_q            <= state_d;
            pc_q               <= pc_d;
            target_q           <= target_d;
            ds_addr_q          <= ds_addr_d;
            req_pc4_q          <= req_pc4_d;
            redirect_pending_q <= redirect_pending_d;
            req_en_q           <= req_en_d;
            id_instr_q         <= id_instr_d;
            id_pc4_q           <= id_pc4_d;
            id_valid_q         <= id_valid_d;
        end
    end

`ifdef FETCH_ADEL_CHECK_EN
    // address-error registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            halt_q        <= 1'b0;
            id_adel_q     <= 1'b0;
            id_badvaddr_q <= 32'h0;
        end else begin
            halt_q        <= halt_d;
            id_adel_q     <= id_adel_d;
            id_badvaddr_q <= id_badvaddr_d;
        end
    end

    assign id_adel_o     = id_adel_q;
    assign id_badvaddr_o = id_badvaddr_q;
`endif

    fetch_skid_buf u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_i       (skid_wr),
        .wr_instr_i (inst_rdata_i),
        .wr_pc4_i   (req_pc4_q),
        .rd_i       (skid_rd),
        .clr_i      (flush_i),
        .valid_o    (skid_valid),
        .instr_o    (skid_instr),
        .pc4_o      (skid_pc4)
    );

    assign id_instr_o = id_instr_q;
    assign id_pc4_o   = id_pc4_q;
    assign id_valid_o = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small instruction-bus responder.
module tb_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        id_stall_i;
    logic        do_branch_i;
    logic [31:0] branch_addr_i;
    logic        jump_flag_i;
    logic        jr_flag_i;
    logic [31:0] jr_addr_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc4_o;
    logic        id_valid_o;
`ifdef FETCH_ADEL_CHECK_EN
    logic        id_adel_o;
    logic [31:0] id_badvaddr_o;
`endif

    int          checks = 0;
    int          errors = 0;
    bit          bus_en;
    int          lat;
    bit          rsp_pend;
    int          rsp_cnt;
    logic [31:0] rsp_addr;
    logic [31:0] flog[$];
    int          nf;

    always #5 clk_i = ~clk_i;

    fetch_stage dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .inst_req_o     (inst_req_o),
        .inst_addr_o    (inst_addr_o),
        .inst_addr_ok_i (inst_addr_ok_i),
        .inst_data_ok_i (inst_data_ok_i),
        .inst_rdata_i   (inst_rdata_i),
        .id_stall_i     (id_stall_i),
        .do_branch_i    (do_branch_i),
        .branch_addr_i  (branch_addr_i),
        .jump_flag_i    (jump_flag_i),
        .jr_flag_i      (jr_flag_i),
        .jr_addr_i      (jr_addr_i),
        .flush_i        (flush_i),
        .flush_pc_i     (flush_pc_i),
        .id_instr_o     (id_instr_o),
        .id_pc4_o       (id_pc4_o),
        .id_valid_o     (id_valid_o)
`ifdef FETCH_ADEL_CHECK_EN
        ,
        .id_adel_o      (id_adel_o),
        .id_badvaddr_o  (id_badvaddr_o)
`endif
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {16'h2400, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: bus inputs set at negedge, outputs observed 1 unit after posedge
    task automatic tick();
        logic hs;
        @(negedge clk_i);
        inst_data_ok_i = rsp_pend && (rsp_cnt == 1);
        inst_rdata_i   = inst_data_ok_i ? mem(rsp_addr) : 32'hDEAD_BEEF;
        inst_addr_ok_i = bus_en && inst_req_o;
        hs = inst_addr_ok_i;
        if (hs) flog.push_back(inst_addr_o);
        @(posedge clk_i);
        if (rsp_pend) begin
            if (inst_data_ok_i) rsp_pend = 1'b0;
            else rsp_cnt--;
        end
        if (hs) begin
            rsp_pend = 1'b1;
            rsp_cnt  = lat;
            rsp_addr = flog[$];
        end
        #1;
    endtask

    task automatic next_valid(input string tag, input logic [31:0] pc4, input logic [31:0] ins);
        int n = 0;
        tick();
        while (!id_valid_o && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, id_valid_o}, 32'd1);
        chk({tag, "_pc4"}, id_pc4_o, pc4);
        chk({tag, "_instr"}, id_instr_o, ins);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0;
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = 32'h0;
        id_stall_i = 1'b0; do_branch_i = 1'b0; branch_addr_i = 32'h0;
        jump_flag_i = 1'b0; jr_flag_i = 1'b0; jr_addr_i = 32'h0;
        flush_i = 1'b0; flush_pc_i = 32'h0;
        bus_en = 1'b1; lat = 1; rsp_pend = 1'b0; rsp_cnt = 0; rsp_addr = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // reset state
        chk("rst_req",   {31'd0, inst_req_o}, 32'd0);
        chk("rst_valid", {31'd0, id_valid_o}, 32'd0);
        chk("rst_instr", id_instr_o, 32'h0000_0000);
        chk("rst_pc4",   id_pc4_o,   32'h0000_0000);

        // first request one cycle after reset
        tick();
        chk("first_req",  {31'd0, inst_req_o}, 32'd1);
        chk("first_addr", inst_addr_o, 32'hBFC0_0000);

        // streaming
        next_valid("s1", 32'hBFC0_0004, mem(32'hBFC0_0000));
        chk("first_fetch", flog[0], 32'hBFC0_0000);
        next_valid("s2", 32'hBFC0_0008, mem(32'hBFC0_0004));
        next_valid("s3", 32'hBFC0_000C, mem(32'hBFC0_0008));
        next_valid("s4", 32'hBFC0_0010, mem(32'hBFC0_000C));
        next_valid("beq", 32'hBFC0_0014, mem(32'hBFC0_0010));

        // taken beq, delay slot not yet issued
        bus_en = 1'b0; do_branch_i = 1'b1; branch_addr_i = 32'hBFC0_0100;
        tick();
        bus_en = 1'b1; do_branch_i = 1'b0;
        nf = flog.size();
        next_valid("ds1", 32'hBFC0_0018, mem(32'hBFC0_0014));
        next_valid("tgt1", 32'hBFC0_0104, mem(32'hBFC0_0100));
        chk("ds1_fetch",  flog[nf],     32'hBFC0_0014);
        chk("tgt1_fetch", flog[nf + 1], 32'hBFC0_0100);
        chk("br1_count",  flog.size(),  nf + 2);

        // five-cycle stall while streaming
        nf = flog.size();
        id_stall_i = 1'b1;
        repeat (5) tick();
        chk("stall_valid", {31'd0, id_valid_o}, 32'd1);
        chk("stall_pc4",   id_pc4_o, 32'hBFC0_0104);
        chk("stall_instr", id_instr_o, mem(32'hBFC0_0100));
        chk("stall_req",   {31'd0, inst_req_o}, 32'd0);
        chk("stall_count", flog.size(), nf + 1);
        id_stall_i = 1'b0;
        tick();
        chk("skid_valid", {31'd0, id_valid_o}, 32'd1);
        chk("skid_pc4",   id_pc4_o, 32'hBFC0_0108);
        chk("skid_instr", id_instr_o, mem(32'hBFC0_0104));
        next_valid("post_skid", 32'hBFC0_010C, mem(32'hBFC0_0108));

        // flush while waiting on a slow response
        lat = 3;
        id_stall_i = 1'b1;
        tick();
        flush_i = 1'b1; flush_pc_i = 32'hBFC0_0380;
        tick();
        flush_i = 1'b0; id_stall_i = 1'b0;
        chk("flush_valid", {31'd0, id_valid_o}, 32'd0);
        chk("flush_req",   {31'd0, inst_req_o}, 32'd0);
        nf = flog.size();
        tick();
        tick();
        chk("drop_valid", {31'd0, id_valid_o}, 32'd0);
        lat = 1;
        next_valid("handler", 32'hBFC0_0384, mem(32'hBFC0_0380));
        chk("handler_fetch", flog[nf], 32'hBFC0_0380);

        // taken branch at 380 with its delay slot already in the skid
        id_stall_i = 1'b1;
        repeat (3) tick();
        nf = flog.size();
        id_stall_i = 1'b0; do_branch_i = 1'b1; branch_addr_i = 32'hBFC0_0500;
        tick();
        do_branch_i = 1'b0;
        chk("ds2_pc4",   id_pc4_o, 32'hBFC0_0388);
        chk("ds2_instr", id_instr_o, mem(32'hBFC0_0384));
        next_valid("tgt2", 32'hBFC0_0504, mem(32'hBFC0_0500));
        chk("tgt2_fetch", flog[nf], 32'hBFC0_0500);
        chk("br2_count",  flog.size(), nf + 1);

        // jr at 500 to a misaligned register target
        bus_en = 1'b0; jr_flag_i = 1'b1; jr_addr_i = 32'h8000_0002;
        tick();
        bus_en = 1'b1; jr_flag_i = 1'b0;
        nf = flog.size();
        next_valid("ds3", 32'hBFC0_0508, mem(32'hBFC0_0504));
        chk("ds3_fetch", flog[nf], 32'hBFC0_0504);
`ifdef FETCH_ADEL_CHECK_EN
        chk("adel_req", {31'd0, inst_req_o}, 32'd0);
        tick();
        chk("adel_flag",  {31'd0, id_adel_o}, 32'd1);
        chk("adel_bad",   id_badvaddr_o, 32'h8000_0002);
        chk("adel_valid", {31'd0, id_valid_o}, 32'd0);
        tick();
        chk("adel_idle",  {31'd0, inst_req_o}, 32'd0);
        chk("adel_count", flog.size(), nf + 1);
`else
        chk("jr_req",  {31'd0, inst_req_o}, 32'd1);
        chk("jr_addr", inst_addr_o, 32'h8000_0000);
        tick();
        chk("jr_fetch", flog[nf + 1], 32'h8000_0000);
        tick();
        chk("jr_pc4", id_pc4_o, 32'h8000_0004);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
